beta_recursion: RTL

- Backward-recursion engine of the 8-state max-log MAP decoder; the reverse-direction counterpart of the forward alpha stage.
- Walks the trellis from step N down to 0, reading branch metrics (gamma) from the gamma store and writing normalized beta vectors to the beta SRAM.
- A start/busy/done handshake lets the decoder controller run it alongside the forward pass.

---
 rtl/beta_recursion.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/beta_recursion.sv
// Backward (beta) recursion engine for an 8-state max-log MAP decoder.
// Walks the trellis from step N down to 0. Each step reads one gamma
// vector, does the add-compare-select and normalisation, and writes one
// normalised beta vector per cycle.
module beta_recursion #(
  parameter int W  = 16,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     blk_len,
  input  logic              term,
  output logic              g_rd,
  output logic [AW-1:0]     g_addr,
  input  logic [16*W-1:0]   g_in,
  output logic              b_we,
  output logic [AW-1:0]     b_addr,
  output logic [8*W-1:0]    b_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_CALC, S_DONE} state_t;

  localparam logic [W-1:0] NEG_INF = {2'b11, {(W-2){1'b0}}};
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  state_t              r_state;
  logic [AW-1:0]       r_n;
  logic                r_term;
  logic [8*W-1:0]      r_beta;
  logic                r_g_rd;
  logic [AW-1:0]       r_g_addr;
  logic                r_b_we;
  logic [AW-1:0]       r_b_addr;
  logic [8*W-1:0]      r_b_out;
  logic                r_busy;
  logic                r_done;

  logic [8*W-1:0]      w_init;
  logic [8*W-1:0]      w_next;
  logic signed [W:0]   w_s0   [8];
  logic signed [W:0]   w_s1   [8];
  logic signed [W:0]   w_max  [8];
  logic [W+1:0]        w_diff [8];

  assign w_init = r_term ? {{7{NEG_INF}}, {W{1'b0}}} : '0;

  // Per-state add-compare-select and normalisation against state 0.
  // Successors of state s are s/2 and s/2+4; which gamma bit feeds the
  // first successor alternates 0,1,1,0 over s mod 4.
  for (genvar s = 0; s < 8; s++) begin : g_acs
    localparam int SUC0 = s / 2;
    localparam int SUC1 = s / 2 + 4;
    localparam int B0   = ((s % 4) == 1 || (s % 4) == 2) ? 1 : 0;
    localparam int GI0  = 2 * s + B0;
    localparam int GI1  = 2 * s + 1 - B0;

    assign w_s0[s] = {r_beta[SUC0*W+W-1], r_beta[SUC0*W +: W]}
                   + {g_in[GI0*W+W-1], g_in[GI0*W +: W]};
    assign w_s1[s] = {r_beta[SUC1*W+W-1], r_beta[SUC1*W +: W]}
                   + {g_in[GI1*W+W-1], g_in[GI1*W +: W]};
    // Ties keep the first operand.
    assign w_max[s]  = (w_s0[s] >= w_s1[s]) ? w_s0[s] : w_s1[s];
    assign w_diff[s] = {w_max[s][W], w_max[s]} - {w_max[0][W], w_max[0]};
    assign w_next[s*W +: W] =
      (w_diff[s][W+1:W-1] == 3'b000 || w_diff[s][W+1:W-1] == 3'b111)
        ? w_diff[s][W-1:0]
        : (w_diff[s][W+1] ? SAT_MIN : SAT_MAX);
  end

  // Control FSM with registered outputs; during CALC r_g_addr doubles as
  // the current step index k, since the gamma for step k is on g_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_term   <= 1'b0;
      r_beta   <= '0;
      r_g_rd   <= 1'b0;
      r_g_addr <= '0;
      r_b_we   <= 1'b0;
      r_b_addr <= '0;
      r_b_out  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_b_we <= 1'b0;
          r_g_rd <= 1'b0;
          // A start coinciding with the done pulse is dropped.
          if (start && !r_done) begin
            r_n     <= blk_len;
            r_term  <= term;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_beta   <= w_init;
          r_b_out  <= w_init;
          r_b_we   <= 1'b1;
          r_b_addr <= r_n;
          if (r_n != '0) begin
            r_g_rd   <= 1'b1;
            r_g_addr <= r_n - AW'(1);
            r_state  <= S_CALC;
          end else begin
            r_g_rd  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_CALC: begin
          r_beta   <= w_next;
          r_b_out  <= w_next;
          r_b_we   <= 1'b1;
          r_b_addr <= r_g_addr;
          if (r_g_addr != '0) begin
            r_g_rd   <= 1'b1;
            r_g_addr <= r_g_addr - AW'(1);
          end else begin
            r_g_rd  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_b_we  <= 1'b0;
          r_g_rd  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign g_rd   = r_g_rd;
  assign g_addr = r_g_addr;
  assign b_we   = r_b_we;
  assign b_addr = r_b_addr;
  assign b_out  = r_b_out;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
